counter_dev: RTL and testbench
==============================

# counter_dev

Programmable down-counter timer that occupies device slot DEV0 behind the processor-side address bridge, decoded at word addresses 0x0000_7F00 (CTRL), 0x0000_7F04 (PRESET) and 0x0000_7F08 (COUNT). The bridge forwards address, write data, write strobe and byte enables only when one of these three addresses is selected, and returns this block's read data to the CPU. The block loads PRESET, counts down once per clock, and raises an interrupt request on terminal count, in either one-shot or auto-reload mode.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- Addr  in  32  DEV0_Addr from bridge; only Addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
- WD  in  32  DEV0_WD write data
- Wr  in  1  DEV0_Wr write strobe; the only qualifier for writes (bridge drives 0 when deselected)
- BE  in  4  DEV0_BE byte enables; BE[i] gates byte lane i (bits 8i+7:8i)
- RD  out  32  DEV0_RD read data, combinational from Addr[3:2]
- IRQ  out  1  interrupt request to CPU

## Operation
- Registers: CTRL[3:0] (bit0 EN, bits2:1 MODE, bit3 IM), CTRL[31:4] read 0; PRESET[31:0] R/W; COUNT[31:0] read-only.
- Writes: when Wr=1 at a rising edge, Addr[3:2]=0 updates CTRL[3:0] from WD byte lane 0 if BE[0]=1; Addr[3:2]=1 updates each PRESET byte whose BE bit is 1. Writes to COUNT or offset 0xC are ignored.
- Reads: RD = {28'b0, CTRL} / PRESET / COUNT / 32'b0 for Addr[3:2] = 0/1/2/3.
- MODE 00: one-shot. MODE 01: auto-reload. MODE 10 and 11 behave as 00.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=0 -> stay; EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE, COUNT holds. Else if COUNT>1, COUNT <= COUNT-1 and stay. Else (COUNT<=1), COUNT <= 0 and go to INT; irq_flag <= 1.
  - INT: one-shot -> EN <= 0, go to IDLE, irq_flag held. Auto-reload -> irq_flag <= 0, go to LOAD.
- IRQ = irq_flag & IM. One-shot: flag stays set until any write to CTRL or PRESET, which clears it on that edge. Auto-reload: flag is a one-cycle pulse during INT.
- PRESET=0 behaves like PRESET=1 (terminal count one cycle after load).

## Timing
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Therefore RD=0 at offsets 0/4/8 and IRQ=0. Reset overrides any concurrent write.
- Write latency: a register write is visible on RD the cycle after the write edge.
- Start latency: a CTRL write setting EN at edge E gives LOAD at E+1, COUNT=PRESET at E+2, then one decrement per edge. IRQ rises after edge E+max(PRESET,1)+2.
- Auto-reload period: max(PRESET,1)+2 cycles between IRQ pulses.
- Clearing EN mid-count: the FSM is in IDLE one edge after the write; COUNT freezes at its value at that edge. Setting EN again reloads from PRESET (no resume).
- A PRESET write mid-count takes effect at the next LOAD only.
- Simultaneous events:
  - The edge entering INT sets irq_flag even if a CTRL/PRESET write occurs on the same edge (set wins).
  - A CTRL write during the INT cycle wins over the one-shot EN clear.
- Toggling IM masks or unmasks IRQ combinationally and does not alter irq_flag.

## Test plan
- Reset: assert reset with Wr=1 to CTRL -> RD=0 at 0x7F00/04/08, IRQ=0, state IDLE.
- One-shot: PRESET=5, CTRL=0x9 written at edge E -> COUNT reads 5,4,3,2,1,0 on edges E+2..E+7. IRQ=1 from E+7 and stays high; EN reads 0. Writing CTRL=0x8 drops IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0,(LOAD),3,…
- Byte enables: PRESET=0, write WD=0xAABBCCDD with BE=4'b0101 -> PRESET reads 0x00BB00DD. Write to 0x7F08 -> COUNT unchanged.
- Stop mid-count: PRESET=10, EN=1, then write CTRL=0x8 when COUNT=6 -> COUNT freezes at 5 or 6 per edge rule, no IRQ. Re-enabling reloads 10.
- Masked / edge cases: PRESET=0, CTRL=0x1 (IM=0) -> irq_flag set after E+3 with IRQ=0. Write CTRL=0x9 -> IRQ stays 0 (flag cleared by write) until the next terminal count.

Source files
------------

// File: rtl/counter_dev.sv
// counter_dev: programmable down-counter timer at DEV0 (CTRL/PRESET/COUNT).
// One-shot or auto-reload, IRQ on terminal count, masked by CTRL.IM.
module counter_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        Wr,
  input  logic [3:0]  BE,
  output logic [31:0] RD,
  output logic        IRQ
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  state_q, state_d;
  logic        irq_q, irq_d;

  logic        wr_ctrl;
  logic        wr_pre;
  logic        en;
  logic        auto_rl;
  logic        unused_addr;

  assign unused_addr = ^{Addr[31:4], Addr[1:0]};
  assign wr_ctrl = Wr && (Addr[3:2] == 2'd0);
  assign wr_pre  = Wr && (Addr[3:2] == 2'd1);
  assign en      = ctrl_q[0];
  assign auto_rl = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = S_INT;
        end
      end
      S_INT: state_d = auto_rl ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // set on entry to INT beats the write-clear on the same edge
  always_comb begin
    irq_d = irq_q;
    if (wr_ctrl || wr_pre) irq_d = 1'b0;
    if (state_q == S_INT && auto_rl) irq_d = 1'b0;
    if (state_q == S_CNT && en && count_q <= 32'd1) irq_d = 1'b1;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (state_q == S_INT && !auto_rl) ctrl_d[0] = 1'b0;
    if (wr_ctrl && BE[0]) ctrl_d = WD[3:0];
  end

  always_comb begin
    preset_d = preset_q;
    if (wr_pre) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) preset_d[8*i +: 8] = WD[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      state_q  <= S_IDLE;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    RD = 32'd0;
    case (Addr[3:2])
      2'd0: RD = {28'd0, ctrl_q};
      2'd1: RD = preset_q;
      2'd2: RD = count_q;
      default: RD = 32'd0;
    endcase
  end

  assign IRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_counter_dev.sv
// tb_counter_dev: directed vector table plus hand sequences
// for auto-reload, stop, masked and same-edge cases.
module tb_counter_dev;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        Wr;
  logic [3:0]  BE;
  logic [31:0] RD;
  logic        IRQ;

  int tests;
  int fails;

  counter_dev dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WD(WD),
    .Wr(Wr), .BE(BE), .RD(RD), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  ra;
    logic [31:0] rd;
    bit          irq;
  } vec_t;

  vec_t vt[22];

  task automatic step(input bit r, input bit w, input logic [1:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [1:0] ra);
    @(negedge clk);
    reset = r;
    Wr    = w;
    Addr  = 32'h0000_7F00 | {28'd0, wa, 2'b00};
    WD    = wd;
    BE    = be;
    @(posedge clk);
    #1;
    Wr    = 1'b0;
    reset = 1'b0;
    Addr  = 32'h0000_7F00 | {28'd0, ra, 2'b00};
    #1;
  endtask

  task automatic idle(input logic [1:0] ra);
    step(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, ra);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic setv(input int i, input bit r, input bit w,
                      input logic [1:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic [1:0] ra,
                      input logic [31:0] rd, input bit irq);
    vt[i].rst = r;  vt[i].wr = w;   vt[i].wa = wa;
    vt[i].wd  = wd; vt[i].be = be;  vt[i].ra = ra;
    vt[i].rd  = rd; vt[i].irq = irq;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    Wr    = 1'b0;
    Addr  = 32'h0000_7F00;
    WD    = 32'd0;
    BE    = 4'h0;

    // reset with concurrent CTRL write
    setv(0,  1, 1, 0, 32'hF, 4'hF, 0, 32'h0, 0);
    setv(1,  0, 0, 0, 32'h0, 4'h0, 1, 32'h0, 0);
    setv(2,  0, 0, 0, 32'h0, 4'h0, 2, 32'h0, 0);
    setv(3,  0, 0, 0, 32'h0, 4'h0, 3, 32'h0, 0);
    // one-shot, PRESET=5, CTRL=9 at edge E (vector 5)
    setv(4,  0, 1, 1, 32'd5, 4'hF, 1, 32'd5, 0);
    setv(5,  0, 1, 0, 32'h9, 4'hF, 0, 32'h9, 0);
    setv(6,  0, 0, 0, 32'h0, 4'h0, 2, 32'd0, 0);
    setv(7,  0, 0, 0, 32'h0, 4'h0, 2, 32'd5, 0);
    setv(8,  0, 0, 0, 32'h0, 4'h0, 2, 32'd4, 0);
    setv(9,  0, 0, 0, 32'h0, 4'h0, 2, 32'd3, 0);
    setv(10, 0, 0, 0, 32'h0, 4'h0, 2, 32'd2, 0);
    setv(11, 0, 0, 0, 32'h0, 4'h0, 2, 32'd1, 0);
    setv(12, 0, 0, 0, 32'h0, 4'h0, 2, 32'd0, 1);
    setv(13, 0, 0, 0, 32'h0, 4'h0, 0, 32'h8, 1);
    setv(14, 0, 0, 0, 32'h0, 4'h0, 2, 32'd0, 1);
    setv(15, 0, 1, 0, 32'h8, 4'hF, 0, 32'h8, 0);
    // byte enables and ignored writes
    setv(16, 0, 1, 1, 32'h0, 4'hF, 1, 32'h0, 0);
    setv(17, 0, 1, 1, 32'hAABBCCDD, 4'b0101, 1, 32'h00BB00DD, 0);
    setv(18, 0, 1, 2, 32'h12345678, 4'hF, 2, 32'h0, 0);
    setv(19, 0, 1, 3, 32'h12345678, 4'hF, 3, 32'h0, 0);
    setv(20, 0, 1, 0, 32'hF, 4'b1110, 0, 32'h8, 0);
    setv(21, 0, 0, 0, 32'h0, 4'h0, 1, 32'h00BB00DD, 0);

    for (int i = 0; i < 22; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].wa, vt[i].wd, vt[i].be, vt[i].ra);
      chk($sformatf("vec%0d_rd", i), RD, vt[i].rd);
      chk_irq($sformatf("vec%0d_irq", i), vt[i].irq);
    end

    // auto-reload PRESET=3: period 5, count 0(load),3,2,1,0(int)
    step(1, 0, 0, 0, 4'h0, 2);
    step(0, 1, 1, 32'd3, 4'hF, 2);
    step(0, 1, 0, 32'hB, 4'hF, 2);
    for (int k = 1; k <= 15; k++) begin
      int ph;
      logic [31:0] ec;
      ph = (k - 1) % 5;
      ec = (ph == 0 || ph == 4) ? 32'd0 : 32'(4 - ph);
      idle(2);
      chk($sformatf("ar_cnt%0d", k), RD, ec);
      chk_irq($sformatf("ar_irq%0d", k), ph == 4);
    end

    // stop mid-count then re-enable
    step(1, 0, 0, 0, 4'h0, 2);
    step(0, 1, 1, 32'd10, 4'hF, 2);
    step(0, 1, 0, 32'h9, 4'hF, 2);
    for (int k = 1; k <= 6; k++) idle(2);
    chk("stop_pre", RD, 32'd6);
    step(0, 1, 0, 32'h8, 4'hF, 2);
    chk("stop_edge", RD, 32'd5);
    for (int k = 0; k < 5; k++) begin
      idle(2);
      chk($sformatf("stop_hold%0d", k), RD, 32'd5);
      chk_irq($sformatf("stop_irq%0d", k), 1'b0);
    end
    step(0, 1, 0, 32'h9, 4'hF, 2);
    idle(2);
    idle(2);
    chk("restart_load", RD, 32'd10);

    // masked terminal count with PRESET=0
    step(1, 0, 0, 0, 4'h0, 2);
    step(0, 1, 0, 32'h1, 4'hF, 2);
    idle(2);
    idle(2);
    idle(2);
    chk_irq("mask_int", 1'b0);
    idle(0);
    chk("mask_en_clr", RD, 32'h0);
    step(0, 1, 0, 32'h9, 4'hF, 2);
    chk_irq("mask_wr", 1'b0);
    idle(2);
    chk_irq("mask_load", 1'b0);
    idle(2);
    chk_irq("mask_cnt", 1'b0);
    idle(2);
    chk_irq("mask_tc", 1'b1);

    // same-edge: PRESET write on INT entry, CTRL write during INT
    step(1, 0, 0, 0, 4'h0, 2);
    step(0, 1, 1, 32'd2, 4'hF, 2);
    step(0, 1, 0, 32'h9, 4'hF, 2);
    idle(2);
    idle(2);
    chk("se_cnt2", RD, 32'd2);
    idle(2);
    chk("se_cnt1", RD, 32'd1);
    step(0, 1, 1, 32'd7, 4'hF, 1);
    chk_irq("se_set_wins", 1'b1);
    chk("se_preset", RD, 32'd7);
    step(0, 1, 0, 32'h9, 4'hF, 0);
    chk("se_ctrl_wins", RD, 32'h9);
    chk_irq("se_ctrl_clr", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
